// File: rtl/dmem_block_responder.sv
// Block-organised data memory responding to data-cache refill/write-back requests.
// Optional macro DMEM_STATS_EN adds saturating read/write completion counters.
module dmem_block_responder #(
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned LATENCY = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_address,
  input  logic [DATA_W-1:0] mem_writedata,
  output logic [DATA_W-1:0] mem_readdata,
  output logic              mem_busywait
`ifdef DMEM_STATS_EN
  ,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
`endif
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   count, count_next;
  logic               wr_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  data_q;
  logic [DATA_W-1:0]  mem [DEPTH];

  logic               busy_c;
  logic               latch_req;
  logic               enter_ack;
  logic               op_write;
  logic [ADDR_W-1:0]  op_addr;
  logic [DATA_W-1:0]  op_data;

  // Next-state logic; op_* select live inputs in IDLE so LATENCY==1 can complete directly.
  always_comb begin
    state_next = state;
    count_next = count;
    busy_c     = 1'b0;
    latch_req  = 1'b0;
    enter_ack  = 1'b0;
    op_write   = wr_q;
    op_addr    = addr_q;
    op_data    = data_q;
    case (state)
      IDLE: begin
        busy_c   = mem_read | mem_write;
        op_write = mem_write;
        op_addr  = mem_address;
        op_data  = mem_writedata;
        if (mem_read | mem_write) begin
          latch_req = 1'b1;
          if (LATENCY == 1) begin
            state_next = ACK;
            enter_ack  = 1'b1;
          end else begin
            state_next = BUSY;
            count_next = CNT_W'(LATENCY - 1);
          end
        end
      end
      BUSY: begin
        busy_c     = 1'b1;
        count_next = count - CNT_W'(1);
        if (count == CNT_W'(1)) begin
          state_next = ACK;
          enter_ack  = 1'b1;
          count_next = '0;
        end
      end
      ACK: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Stall drops the instant reset asserts, even with a request pending on the inputs.
  assign mem_busywait = busy_c & ~reset;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      count        <= '0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      mem_readdata <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
      if (latch_req) begin
        wr_q   <= mem_write;
        addr_q <= mem_address;
        data_q <= mem_writedata;
      end
      if (enter_ack && !op_write) begin
        mem_readdata <= mem[op_addr];
      end
    end
  end

  // Block array; a write is committed only on the edge entering ACK.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (enter_ack && op_write) begin
      mem[op_addr] <= op_data;
    end
  end

`ifdef DMEM_STATS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (enter_ack) begin
      if (op_write) begin
        if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
      end else begin
        if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
      end
    end
  end
`endif

endmodule
